// File: rtl/ws2812_rx_pkg.sv
// ws2812_rx_pkg: constants, types and helpers shared by the WS2812 receiver.
//   - Pixel geometry and the 12 MHz line timing, the same values the
//     transmitter uses.
//   - rx_state_e: the receiver's frame-tracking states.
//   - wire_to_rgb(): reorders a pixel from wire order {G,R,B} to {R,G,B}.
package ws2812_rx_pkg;

    localparam int BITS_PER_PIXEL = 24;

    // Line timing in 12 MHz clock cycles.
    localparam int T0H            = 5;    // high width of a 0 bit
    localparam int T1H            = 10;   // high width of a 1 bit
    localparam int T_BIT          = 15;   // full bit period
    localparam int T_THRESH_12M   = 7;    // midpoint between T0H and T1H
    localparam int T_MAX_HIGH_12M = 14;   // longest legal high pulse
    localparam int T_RESET_12M    = 600;  // 50 us latch gap

    // Wire colour order is G7..G0, R7..R0, B7..B0, MSB first.
    typedef enum logic [1:0] {
        ST_SYNC,   // waiting for a latch gap before trusting the line
        ST_IDLE,   // latched, waiting for the first bit of a frame
        ST_HIGH,   // measuring the high part of a bit
        ST_LOW     // measuring the low part of a bit or the latch gap
    } rx_state_e;

    function automatic logic [23:0] wire_to_rgb(input logic [23:0] grb);
        return {grb[15:8], grb[23:16], grb[7:0]};
    endfunction

endpackage

// File: rtl/ws2812_rx_sync.sv
// ws2812_rx_sync: brings the asynchronous WS2812 line into the hwclk domain.
//   hwclk  in   system clock
//   reset  in   synchronous, active-high
//   din    in   raw serial line
//   level  out  synchronized line level (2 cycles behind din)
//   rise   out  1 on the first synchronized high cycle
//   fall   out  1 on the first synchronized low cycle
module ws2812_rx_sync (
    input  logic hwclk,
    input  logic reset,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic meta;
    logic sync_q;
    logic prev_q;

    // NOTE: flops use non-blocking assignment so each stage samples the
    // value its neighbour held before this edge, giving a true pipeline.
    always_ff @(posedge hwclk) begin
        if (reset) begin
            meta   <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta   <= din;
            sync_q <= meta;
            prev_q <= sync_q;
        end
    end

    assign level = sync_q;
    assign rise  = sync_q & ~prev_q;
    assign fall  = ~sync_q & prev_q;

endmodule

// File: rtl/ws2812_rx.sv
// ws2812_rx: WS2812 single-wire receiver. Measures high-pulse widths, decodes
// bits, assembles 24-bit pixels and stores a frame in transmitter layout.
//   hwclk            in   system clock
//   reset            in   synchronous, active-high
//   ws_din           in   serial WS2812 data, asynchronous to hwclk
//   pixel_rgb        out  last decoded pixel {R,G,B}
//   pixel_valid      out  strobe: pixel_rgb / pixel_index valid
//   pixel_index      out  position of that pixel in the frame
//   packed_rgb_data  out  pixel i at [24*i +: 24], {R,G,B}
//   frame_done       out  strobe on the latch gap ending a frame
//   frame_pixels     out  pixels accepted in the frame just ended
//   err_timing       out  strobe: high pulse longer than T_MAX_HIGH
//   err_overflow     out  strobe: pixel beyond NUM_LEDS dropped
//   err_partial      out  strobe: frame ended mid-pixel
module ws2812_rx
    import ws2812_rx_pkg::*;
#(
    parameter int NUM_LEDS   = 16,
    parameter int T_THRESH   = T_THRESH_12M,
    parameter int T_MAX_HIGH = T_MAX_HIGH_12M,
    parameter int T_RESET    = T_RESET_12M
) (
    input  logic                               hwclk,
    input  logic                               reset,
    input  logic                               ws_din,
    output logic [BITS_PER_PIXEL-1:0]          pixel_rgb,
    output logic                               pixel_valid,
    output logic [$clog2(NUM_LEDS)-1:0]        pixel_index,
    output logic [BITS_PER_PIXEL*NUM_LEDS-1:0] packed_rgb_data,
    output logic                               frame_done,
    output logic [$clog2(NUM_LEDS+1)-1:0]      frame_pixels,
    output logic                               err_timing,
    output logic                               err_overflow,
    output logic                               err_partial
);

    localparam int IDX_W = $clog2(NUM_LEDS);
    localparam int PW    = $clog2(NUM_LEDS + 1);
    localparam int TW    = $clog2(T_RESET + 1);

    // The timer holds the number of cycles already spent in the current
    // level, so "this cycle is the N-th" compares against N-1.
    localparam logic [TW-1:0] THRESH_CNT   = TW'(T_THRESH);
    localparam logic [TW-1:0] MAX_HIGH_CNT = TW'(T_MAX_HIGH);
    localparam logic [TW-1:0] RESET_CNT    = TW'(T_RESET - 1);
    localparam logic [TW-1:0] ONE_CNT      = TW'(1);
    localparam logic [PW-1:0] NUM_LEDS_P   = PW'(NUM_LEDS);
    localparam logic [4:0]    LAST_BIT     = 5'(BITS_PER_PIXEL - 1);

    logic level;
    logic rise;
    logic fall;

    ws2812_rx_sync u_sync (
        .hwclk (hwclk),
        .reset (reset),
        .din   (ws_din),
        .level (level),
        .rise  (rise),
        .fall  (fall)
    );

    rx_state_e state;
    rx_state_e state_next;

    logic [TW-1:0]             cnt;
    logic [TW-1:0]             cnt_inc;
    logic [TW-1:0]             cnt_next;
    logic [4:0]                bit_cnt;
    logic [PW-1:0]             index;
    logic [BITS_PER_PIXEL-2:0] shift_reg;
    logic [BITS_PER_PIXEL-1:0] shift_next;
    logic                      bit_val;
    logic                      shift_en;
    logic                      frame_end;
    logic                      timing_err;

    assign cnt_inc    = (cnt == '1) ? cnt : cnt + ONE_CNT;
    assign shift_next = {shift_reg, bit_val};

    // State register.
    always_ff @(posedge hwclk) begin
        if (reset) begin
            state <= ST_SYNC;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    // NOTE: state_next gets a default before the case so every path assigns
    // it and no latch is inferred.
    always_comb begin
        state_next = state;
        unique case (state)
            ST_SYNC: if (!level && cnt >= RESET_CNT) state_next = ST_IDLE;
            ST_IDLE: if (rise) state_next = ST_HIGH;
            ST_HIGH: begin
                if (fall)                     state_next = ST_LOW;
                else if (cnt >= MAX_HIGH_CNT) state_next = ST_SYNC;
            end
            ST_LOW: begin
                if (rise)                  state_next = ST_HIGH;
                else if (cnt >= RESET_CNT) state_next = ST_IDLE;
            end
            default: state_next = ST_SYNC;
        endcase
    end

    // Output / datapath-control logic.
    always_comb begin
        cnt_next   = cnt_inc;
        bit_val    = (cnt >= THRESH_CNT);
        shift_en   = 1'b0;
        frame_end  = 1'b0;
        timing_err = 1'b0;
        unique case (state)
            ST_SYNC: begin
                // Any high level restarts the wait for a full gap.
                if (level) cnt_next = '0;
            end
            ST_IDLE: begin
                cnt_next = rise ? ONE_CNT : '0;
            end
            ST_HIGH: begin
                if (fall) begin
                    shift_en = 1'b1;
                    cnt_next = ONE_CNT;
                end else if (cnt >= MAX_HIGH_CNT) begin
                    // This cycle is high pulse cycle T_MAX_HIGH+1.
                    timing_err = 1'b1;
                    cnt_next   = '0;
                end
            end
            ST_LOW: begin
                if (rise) begin
                    cnt_next = ONE_CNT;
                end else if (cnt >= RESET_CNT) begin
                    // LOW is only reached after a decoded bit, so a frame
                    // ending here always carries at least one bit.
                    frame_end = 1'b1;
                    cnt_next  = '0;
                end
            end
            default: cnt_next = '0;
        endcase
    end

    // Counters, shift register, pixel store and output strobes.
    always_ff @(posedge hwclk) begin
        if (reset) begin
            cnt             <= '0;
            bit_cnt         <= '0;
            index           <= '0;
            shift_reg       <= '0;
            pixel_rgb       <= '0;
            pixel_valid     <= 1'b0;
            pixel_index     <= '0;
            // NOTE: the pixel store is reset too because reset must drive
            // every output, packed_rgb_data included, to zero.
            packed_rgb_data <= '0;
            frame_done      <= 1'b0;
            frame_pixels    <= '0;
            err_timing      <= 1'b0;
            err_overflow    <= 1'b0;
            err_partial     <= 1'b0;
        end else begin
            cnt          <= cnt_next;
            pixel_valid  <= 1'b0;
            frame_done   <= 1'b0;
            err_timing   <= 1'b0;
            err_overflow <= 1'b0;
            err_partial  <= 1'b0;

            if (timing_err) begin
                // Drop the partial pixel; stored pixels stay as written.
                err_timing <= 1'b1;
                bit_cnt    <= '0;
                index      <= '0;
            end else if (frame_end) begin
                frame_done   <= 1'b1;
                frame_pixels <= index;
                err_partial  <= (bit_cnt != '0);
                bit_cnt      <= '0;
                index        <= '0;
            end else if (shift_en) begin
                shift_reg <= shift_next[BITS_PER_PIXEL-2:0];
                if (bit_cnt == LAST_BIT) begin
                    bit_cnt <= '0;
                    if (index < NUM_LEDS_P) begin
                        pixel_valid <= 1'b1;
                        pixel_rgb   <= wire_to_rgb(shift_next);
                        pixel_index <= index[IDX_W-1:0];
                        packed_rgb_data[BITS_PER_PIXEL*index +: BITS_PER_PIXEL]
                            <= wire_to_rgb(shift_next);
                        index       <= index + PW'(1);
                    end else begin
                        // Index parks at NUM_LEDS so later pixels also overflow.
                        err_overflow <= 1'b1;
                    end
                end else begin
                    bit_cnt <= bit_cnt + 5'd1;
                end
            end
        end
    end

endmodule
